// File: rtl/turtle_program_loader_pkg.sv
// Shared definitions for the turtle program loader: FSM state encoding,
// frame start byte and the running-checksum helper.
package turtle_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CNT_HI   = 3'd1,
        ST_CNT_LO   = 3'd2,
        ST_INSTR_HI = 3'd3,
        ST_INSTR_LO = 3'd4,
        ST_WRITE    = 3'd5,
        ST_CHECK    = 3'd6
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC           = 8'hA5;
    localparam int         LOADER_BYTES_PER_INSTR = 2;

    // Frame checksum is a plain XOR of every byte after the start byte.
    function automatic logic [7:0] loader_chk_update(input logic [7:0] chk,
                                                     input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/turtle_program_loader.sv
// Turtle program loader: parses MAGIC, CNT_HI, CNT_LO, N x (HI, LO), CHK
// from a byte stream, writes each 16-bit word to instruction memory and
// keeps the CPU held in reset until a frame with a good checksum arrives.
// Optional build macro LOADER_TIMEOUT_EN adds an inter-byte timeout.
module turtle_program_loader
    import turtle_program_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 12,
    parameter int         INSTR_WIDTH    = 16,
    parameter logic [7:0] MAGIC          = LOADER_MAGIC,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   load_done,
    output logic                   load_error
);

    loader_state_t                 state_q, state_d;
    logic [7:0]                    chk_q, chk_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [7:0]                    hi_q, hi_d;
    logic                          imem_we_q, imem_we_d;
    logic [INSTR_WIDTH-1:0]        wdata_q, wdata_d;
    logic                          rx_ready_q, rx_ready_d;
    logic                          cpu_hold_q, cpu_hold_d;
    logic                          busy_q, busy_d;
    logic                          load_done_q, load_done_d;
    logic                          load_error_q, load_error_d;
    logic                          accept_s;
    logic [15:0]                   cnt_new_s;
    logic [8*LOADER_BYTES_PER_INSTR-1:0] word_s;
`ifdef LOADER_TIMEOUT_EN
    logic [31:0]                   to_cnt_q, to_cnt_d;
`endif

    assign accept_s  = rx_valid && rx_ready_q;
    assign cnt_new_s = {cnt_q[15:8], rx_data};
    assign word_s    = {hi_q, rx_data};

    // Next-state and datapath decode for the frame parser.
    always_comb begin
        state_d      = state_q;
        chk_d        = chk_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        hi_d         = hi_q;
        imem_we_d    = 1'b0;
        wdata_d      = wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;
`ifdef LOADER_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (rx_data == MAGIC)) begin
                    state_d      = ST_CNT_HI;
                    cpu_hold_d   = 1'b1;
                    load_error_d = 1'b0;
                    chk_d        = 8'h00;
                    addr_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT_HI: begin
                if (accept_s) begin
                    cnt_d   = {rx_data, cnt_q[7:0]};
                    chk_d   = loader_chk_update(chk_q, rx_data);
                    state_d = ST_CNT_LO;
                end else begin
                    state_d = ST_CNT_HI;
                end
            end
            ST_CNT_LO: begin
                if (accept_s) begin
                    cnt_d = cnt_new_s;
                    chk_d = loader_chk_update(chk_q, rx_data);
                    // A count larger than the memory is rejected before any write.
                    if ({16'h0000, cnt_new_s} > (32'd1 << ADDR_WIDTH)) begin
                        load_error_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (cnt_new_s == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_INSTR_HI;
                    end
                end else begin
                    state_d = ST_CNT_LO;
                end
            end
            ST_INSTR_HI: begin
                if (accept_s) begin
                    hi_d    = rx_data;
                    chk_d   = loader_chk_update(chk_q, rx_data);
                    state_d = ST_INSTR_LO;
                end else begin
                    state_d = ST_INSTR_HI;
                end
            end
            ST_INSTR_LO: begin
                if (accept_s) begin
                    chk_d     = loader_chk_update(chk_q, rx_data);
                    wdata_d   = INSTR_WIDTH'(word_s);
                    imem_we_d = 1'b1;
                    state_d   = ST_WRITE;
                end else begin
                    state_d = ST_INSTR_LO;
                end
            end
            ST_WRITE: begin
                // Address wraps naturally when N equals the memory depth.
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? ST_CHECK : ST_INSTR_HI;
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (rx_data == chk_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef LOADER_TIMEOUT_EN
        // Inter-byte watchdog: any accepted byte restarts it, IDLE parks it.
        if ((state_q == ST_IDLE) || accept_s) begin
            to_cnt_d = 32'd0;
        end else if ((to_cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
            to_cnt_d     = 32'd0;
            load_error_d = 1'b1;
            imem_we_d    = 1'b0;
            state_d      = ST_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
`endif
        rx_ready_d = (state_d != ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            chk_q        <= 8'h00;
            cnt_q        <= 16'd0;
            addr_q       <= '0;
            hi_q         <= 8'h00;
            imem_we_q    <= 1'b0;
            wdata_q      <= '0;
            rx_ready_q   <= 1'b1;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            to_cnt_q     <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            chk_q        <= chk_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            imem_we_q    <= imem_we_d;
            wdata_q      <= wdata_d;
            rx_ready_q   <= rx_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
`ifdef LOADER_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    // A write in flight is suppressed during the reset cycle itself.
    assign imem_we    = imem_we_q && !reset;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign rx_ready   = rx_ready_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_turtle_program_loader.sv
// Scoreboard bench for turtle_program_loader: stimulus pushes expected
// memory writes / load_done pulses, a monitor pops and compares them.
module tb_turtle_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_done;
        logic [11:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    turtle_program_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_write(input logic [11:0] a, input logic [15:0] d);
        ev_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_done();
        ev_t e;
        e.is_done = 1'b1;
        e.addr    = 12'h000;
        e.data    = 16'h0000;
        exp_q.push_back(e);
    endtask

    // Monitor: every write / done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (rx_ready !== !imem_we) begin
                bad++;
                $display("FAIL rx_ready_vs_write: rx_ready=%0b imem_we=%0b", rx_ready, imem_we);
            end
            if (imem_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h", imem_addr, imem_wdata);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.is_done || (e.addr !== imem_addr) || (e.data !== imem_wdata)) begin
                        bad++;
                        $display("FAIL write: got %0h@%0h want done=%0b %0h@%0h",
                                 imem_wdata, imem_addr, e.is_done, e.data, e.addr);
                    end
                end
            end
            if (load_done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got load_done=1 want none");
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (!e.is_done) begin
                        bad++;
                        $display("FAIL done: got load_done want write %0h@%0h", e.data, e.addr);
                    end
                end
            end
        end
    end

    // Present one byte, hold it until accepted; rx_valid stays high afterwards.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while ((rx_ready !== 1'b1) && (guard < 20)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 want 1");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream n bytes back-to-back from a packed word, first byte most significant.
    task automatic send_seq(input int n, input logic [63:0] bytes);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[8*(n-1-i) +: 8]);
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic hold, input logic err);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
        chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", {20'd0, imem_addr}, 32'd0);
        chk("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_error", {31'd0, load_error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word load; checksum 02^12^34^AB^CD = 42.
        expect_write(12'h000, 16'h1234);
        expect_write(12'h001, 16'hABCD);
        expect_done();
        send_seq(8, 64'hA5_00_02_12_34_AB_CD_42);
        check_status("good", 1'b0, 1'b0);

        // MAGIC re-arms the hold before anything else happens.
        send_byte(8'hA5);
        chk("magic_hold", {31'd0, cpu_hold}, 32'd1);
        chk("magic_busy", {31'd0, busy}, 32'd1);
        // Rest of a frame with a wrong checksum: writes happen, error sticks.
        expect_write(12'h000, 16'h1234);
        expect_write(12'h001, 16'hABCD);
        send_seq(7, 64'h00_02_12_34_AB_CD_00);
        check_status("badchk", 1'b1, 1'b1);

        // Empty frame: no writes, good checksum of 00.
        expect_done();
        send_seq(4, 64'hA5_00_00_00);
        check_status("empty", 1'b0, 1'b0);

        // N = 4097 exceeds a 4096-word memory.
        send_seq(3, 64'hA5_10_01);
        check_status("oversize", 1'b1, 1'b1);

        // Next valid frame clears the error.
        expect_done();
        send_seq(4, 64'hA5_00_00_00);
        check_status("recover", 1'b0, 1'b0);

        // Garbage in IDLE is ignored, then a normal load.
        send_seq(3, 64'hFF_00_3C);
        chk("garbage_busy", {31'd0, busy}, 32'd0);
        expect_write(12'h000, 16'h1234);
        expect_write(12'h001, 16'hABCD);
        expect_done();
        send_seq(8, 64'hA5_00_02_12_34_AB_CD_42);
        check_status("after_garbage", 1'b0, 1'b0);

        // MAGIC inside the payload is plain data; 01^A5^5A = FE.
        expect_write(12'h000, 16'hA55A);
        expect_done();
        send_seq(6, 64'hA5_00_01_A5_5A_FE);
        check_status("magic_data", 1'b0, 1'b0);

        // Reset after INSTR_HI aborts the frame.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h77);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        expect_done();
        send_seq(4, 64'hA5_00_00_00);
        check_status("post_reset", 1'b0, 1'b0);

`ifdef LOADER_TIMEOUT_EN
        // Stall after CNT_HI until the watchdog fires.
        send_byte(8'hA5);
        send_byte(8'h00);
        rx_valid = 1'b0;
        repeat (90) @(negedge clk);
        chk("to_still_busy", {31'd0, busy}, 32'd1);
        chk("to_no_error_yet", {31'd0, load_error}, 32'd0);
        repeat (20) @(negedge clk);
        check_status("timeout", 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
